// File: rtl/sprite_frame_sched_if.sv
// Host configuration port of sprite_frame_sched: a held request with a one-cycle ack.
interface sprite_frame_sched_if;
  logic        req;
  logic [1:0]  addr;
  logic [11:0] data;
  logic        ack;

  modport master (output req, output addr, output data, input ack);
  modport slave  (input req, input addr, input data, output ack);
endinterface

// File: rtl/sprite_frame_sched.sv
// Frame-synchronous sprite configuration controller: double-buffered host writes are
// committed at vertical-blank entry, and the bounce offset and blink schedule advance once per frame.
module sprite_frame_sched #(
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080,
  parameter int SPRITE_SIZE  = 64,
  parameter int BOUNCE_AMP   = 32,
  parameter int BLINK_PERIOD = 256,
  parameter int BLINK_LEN    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cen_i,
  input  logic [1:0]           vh_blank_i,
  sprite_frame_sched_if.slave  cfg,
  output logic [11:0]          sprite_x_o,
  output logic [10:0]          sprite_y_o,
  output logic                 sprite_en_o,
  output logic                 blink_o,
  output logic [15:0]          frame_cnt_o,
  output logic                 commit_o,
  output logic                 busy_o
);

  localparam int PW = (2 * BOUNCE_AMP > 2) ? $clog2(2 * BOUNCE_AMP) : 1;
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPRITE_SIZE);
  localparam logic [11:0] X_RST = 12'(H_ACTIVE / 2 - SPRITE_SIZE / 2);
  localparam logic [10:0] Y_RST = 11'(V_ACTIVE / 2 - SPRITE_SIZE / 2);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t        state_q, state_d;
  logic          vblank_q, vblank_d;
  logic          ack_q, ack_d;
  logic          commit_q, commit_d;
  logic          busy_q, busy_d;
  logic [11:0]   px_q, px_d, ax_q, ax_d;
  logic [10:0]   py_q, py_d, ay_q, ay_d;
  logic          pen_q, pen_d, aen_q, aen_d;
  logic          pauto_q, pauto_d, aauto_q, aauto_d;
  logic [PW-1:0] p_q, p_d;
  logic [15:0]   frame_q, frame_d;
  logic [10:0]   y_q, y_d;
  logic          blink_q, blink_d;
  logic          fe;
  logic          accept;
  logic [10:0]   tri_off;

  always_comb begin
    state_d  = state_q;
    vblank_d = vblank_q;
    ack_d    = ack_q;
    commit_d = commit_q;
    px_d     = px_q;
    py_d     = py_q;
    pen_d    = pen_q;
    pauto_d  = pauto_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    aen_d    = aen_q;
    aauto_d  = aauto_q;
    p_d      = p_q;
    frame_d  = frame_q;

    fe = cen_i && vh_blank_i[1] && !vblank_q;
    // A frame event in PENDING belongs to the commit, so a simultaneous write waits
    accept = cen_i && cfg.req && !ack_q && (state_q != COMMIT) &&
             !((state_q == PENDING) && fe);

    if (cen_i) begin
      vblank_d = vh_blank_i[1];
      ack_d    = accept;
      commit_d = 1'b0;

      if (accept) begin
        case (cfg.addr)
          2'd0:    px_d = (cfg.data > X_MAX) ? X_MAX : cfg.data;
          2'd1:    py_d = (cfg.data[10:0] > Y_MAX) ? Y_MAX : cfg.data[10:0];
          2'd2:    {pauto_d, pen_d} = cfg.data[1:0];
          default: ;
        endcase
      end

      if (fe) begin
        frame_d = frame_q + 16'd1;
        if (aauto_q) p_d = (p_q == PW'(2 * BOUNCE_AMP - 1)) ? '0 : p_q + 1'b1;
      end

      case (state_q)
        IDLE:    if (accept && (cfg.addr == 2'd3)) state_d = PENDING;
        PENDING: if (fe) begin
                   state_d  = COMMIT;
                   commit_d = 1'b1;
                 end
        COMMIT:  begin
                   ax_d    = px_q;
                   ay_d    = py_q;
                   aen_d   = pen_q;
                   aauto_d = pauto_q;
                   state_d = IDLE;
                 end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);

    // Outputs are registered from next-state values so they move with the counters
    tri_off = (p_d < PW'(BOUNCE_AMP)) ? 11'(p_d) : 11'(2 * BOUNCE_AMP - 1) - 11'(p_d);
    if (aauto_d) y_d = (tri_off > ay_d) ? 11'd0 : ay_d - tri_off;
    else         y_d = ay_d;
    blink_d = aen_d &&
              ((frame_d & 16'(BLINK_PERIOD - 1)) >= 16'(BLINK_PERIOD - BLINK_LEN));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      vblank_q <= 1'b0;
      ack_q    <= 1'b0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      px_q     <= X_RST;
      py_q     <= Y_RST;
      pen_q    <= 1'b1;
      pauto_q  <= 1'b1;
      ax_q     <= X_RST;
      ay_q     <= Y_RST;
      aen_q    <= 1'b1;
      aauto_q  <= 1'b1;
      p_q      <= '0;
      frame_q  <= 16'd0;
      y_q      <= Y_RST;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank_d;
      ack_q    <= ack_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pen_q    <= pen_d;
      pauto_q  <= pauto_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      aen_q    <= aen_d;
      aauto_q  <= aauto_d;
      p_q      <= p_d;
      frame_q  <= frame_d;
      y_q      <= y_d;
      blink_q  <= blink_d;
    end
  end

  assign cfg.ack     = ack_q;
  assign commit_o    = commit_q;
  assign busy_o      = busy_q;
  assign sprite_x_o  = ax_q;
  assign sprite_y_o  = y_q;
  assign sprite_en_o = aen_q;
  assign blink_o     = blink_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_sprite_frame_sched.sv
// Scoreboard bench for sprite_frame_sched: a behavioural model pushes expected per-frame
// outputs and write acks, which are popped and compared as the DUT produces them.
module tb_sprite_frame_sched;
  localparam int H   = 1920;
  localparam int V   = 1080;
  localparam int SZ  = 64;
  localparam int AMP = 32;
  localparam int BP  = 256;
  localparam int BL  = 8;

  typedef struct {
    int x;
    int y;
    bit en;
    bit blink;
    int fc;
    bit commit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [1:0]  vh;
  logic [11:0] sprite_x;
  logic [10:0] sprite_y;
  logic        sprite_en, blink, commit, busy;
  logic [15:0] frame_cnt;

  sprite_frame_sched_if cfg_if ();

  sprite_frame_sched #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SPRITE_SIZE(SZ),
    .BOUNCE_AMP(AMP), .BLINK_PERIOD(BP), .BLINK_LEN(BL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .vh_blank_i(vh),
    .cfg(cfg_if),
    .sprite_x_o(sprite_x), .sprite_y_o(sprite_y), .sprite_en_o(sprite_en),
    .blink_o(blink), .frame_cnt_o(frame_cnt), .commit_o(commit), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  bit ack_sb[$];

  int mx, my, mpx, mpy, mp, mframe;
  bit men, mauto, mpen, mpauto, mpend;

  task automatic model_reset();
    mx = H / 2 - SZ / 2; my = V / 2 - SZ / 2; men = 1; mauto = 1;
    mpx = mx; mpy = my; mpen = 1; mpauto = 1; mpend = 0;
    mp = 0; mframe = 0;
  endtask

  function automatic int exp_y();
    int t, y;
    t = (mp < AMP) ? mp : 2 * AMP - 1 - mp;
    y = my - t;
    if (y < 0) y = 0;
    return mauto ? y : my;
  endfunction

  task automatic model_fe(output exp_t e);
    mframe = (mframe + 1) % 65536;
    if (mauto) mp = (mp + 1) % (2 * AMP);
    e.commit = mpend;
    if (mpend) begin
      mx = mpx; my = mpy; men = mpen; mauto = mpauto; mpend = 0;
    end
    e.x = mx; e.y = exp_y(); e.en = men; e.fc = mframe;
    e.blink = men && ((mframe % BP) >= BP - BL);
  endtask

  task automatic model_write(input int addr, input int data);
    case (addr)
      0: mpx = (data > H - SZ) ? H - SZ : data;
      1: mpy = ((data % 2048) > V - SZ) ? V - SZ : data % 2048;
      2: begin mpen = data[0]; mpauto = data[1]; end
      default: mpend = 1;
    endcase
  endtask

  task automatic cfg_write(input int addr, input int data);
    bit exp_ack;
    @(posedge clk); #1;
    cfg_if.req = 1'b1; cfg_if.addr = 2'(addr); cfg_if.data = 12'(data);
    ack_sb.push_back(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cfg_if.ack) break;
    end
    exp_ack = ack_sb.pop_front();
    total++;
    if (cfg_if.ack !== exp_ack) begin
      bad++; $display("FAIL write_ack addr=%0d got=%b exp=%b", addr, cfg_if.ack, exp_ack);
    end
    cfg_if.req = 1'b0;
    model_write(addr, data);
    @(posedge clk); #1;
    total++;
    if (cfg_if.ack !== 1'b0) begin
      bad++; $display("FAIL ack_pulse addr=%0d got=%b exp=0", addr, cfg_if.ack);
    end
  endtask

  task automatic run_frame();
    exp_t e;
    logic c_seen;
    @(posedge clk); #1; vh = 2'b10;
    model_fe(e);
    sb.push_back(e);
    @(posedge clk); #1; c_seen = commit;
    @(posedge clk); #1;
    vh = 2'b00;
    @(posedge clk); #1;
    e = sb.pop_front();
    total += 7;
    if (sprite_x !== 12'(e.x)) begin bad++; $display("FAIL frame_x fc=%0d got=%0d exp=%0d", e.fc, sprite_x, e.x); end
    if (sprite_y !== 11'(e.y)) begin bad++; $display("FAIL frame_y fc=%0d got=%0d exp=%0d", e.fc, sprite_y, e.y); end
    if (sprite_en !== e.en) begin bad++; $display("FAIL frame_en fc=%0d got=%b exp=%b", e.fc, sprite_en, e.en); end
    if (blink !== e.blink) begin bad++; $display("FAIL frame_blink fc=%0d got=%b exp=%b", e.fc, blink, e.blink); end
    if (frame_cnt !== 16'(e.fc)) begin bad++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, e.fc); end
    if (c_seen !== e.commit) begin bad++; $display("FAIL frame_commit fc=%0d got=%b exp=%b", e.fc, c_seen, e.commit); end
    if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy fc=%0d got=%b exp=0", e.fc, busy); end
  endtask

  task automatic check_reset_outputs(input string tag);
    total += 8;
    if (sprite_x !== 12'(H / 2 - SZ / 2)) begin bad++; $display("FAIL %s_x got=%0d exp=%0d", tag, sprite_x, H / 2 - SZ / 2); end
    if (sprite_y !== 11'(V / 2 - SZ / 2)) begin bad++; $display("FAIL %s_y got=%0d exp=%0d", tag, sprite_y, V / 2 - SZ / 2); end
    if (sprite_en !== 1'b1) begin bad++; $display("FAIL %s_en got=%b exp=1", tag, sprite_en); end
    if (blink !== 1'b0) begin bad++; $display("FAIL %s_blink got=%b exp=0", tag, blink); end
    if (frame_cnt !== 16'd0) begin bad++; $display("FAIL %s_fc got=%0d exp=0", tag, frame_cnt); end
    if (cfg_if.ack !== 1'b0) begin bad++; $display("FAIL %s_ack got=%b exp=0", tag, cfg_if.ack); end
    if (commit !== 1'b0) begin bad++; $display("FAIL %s_commit got=%b exp=0", tag, commit); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b1; vh = 2'b00;
    cfg_if.req = 1'b0; cfg_if.addr = 2'd0; cfg_if.data = 12'd0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_idle_frames();
    for (int i = 0; i < 3; i++) run_frame();
  endtask

  task automatic test_write_commit();
    cfg_write(0, 2000);
    cfg_write(1, 100);
    cfg_write(2, 1);
    cfg_write(3, 0);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL wc_busy got=%b exp=1", busy); end
    if (sprite_x !== 12'(mx)) begin bad++; $display("FAIL wc_hold_x got=%0d exp=%0d", sprite_x, mx); end
    run_frame();
  endtask

  task automatic test_bounce();
    cfg_write(1, 10);
    cfg_write(2, 3);
    cfg_write(3, 0);
    run_frame();
    for (int i = 0; i < 64; i++) run_frame();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit exp_ack;
    cfg_write(0, 40);
    cfg_write(3, 0);
    @(posedge clk); #1;
    vh = 2'b10; cfg_if.req = 1'b1; cfg_if.addr = 2'd0; cfg_if.data = 12'd700;
    model_fe(e);
    ack_sb.push_back(1'b1);
    @(posedge clk); #1;
    total += 2;
    if (commit !== 1'b1) begin bad++; $display("FAIL collide_commit got=%b exp=1", commit); end
    if (cfg_if.ack !== 1'b0) begin bad++; $display("FAIL collide_ack_fe got=%b exp=0", cfg_if.ack); end
    @(posedge clk); #1;
    total += 2;
    if (cfg_if.ack !== 1'b0) begin bad++; $display("FAIL collide_ack_commit got=%b exp=0", cfg_if.ack); end
    if (sprite_x !== 12'(mx)) begin bad++; $display("FAIL collide_x got=%0d exp=%0d", sprite_x, mx); end
    for (int i = 0; i < 20; i++) begin
      if (cfg_if.ack) break;
      @(posedge clk); #1;
    end
    exp_ack = ack_sb.pop_front();
    total++;
    if (cfg_if.ack !== exp_ack) begin bad++; $display("FAIL collide_late_ack got=%b exp=%b", cfg_if.ack, exp_ack); end
    cfg_if.req = 1'b0;
    model_write(0, 700);
    @(posedge clk); #1;
    total++;
    if (sprite_x !== 12'(mx)) begin bad++; $display("FAIL collide_hold_x got=%0d exp=%0d", sprite_x, mx); end
    vh = 2'b00;
    @(posedge clk); #1;
    cfg_write(3, 0);
    run_frame();
  endtask

  task automatic test_blink();
    cfg_write(2, 3);
    cfg_write(3, 0);
    run_frame();
    while (mframe < 260) run_frame();
    cfg_write(2, 0);
    cfg_write(3, 0);
    for (int i = 0; i < 256; i++) run_frame();
  endtask

  task automatic test_cen_freeze();
    exp_t e;
    int old_x, old_fc;
    cfg_write(0, 300);
    cfg_write(3, 0);
    old_x = mx;
    @(posedge clk); #1; vh = 2'b10;
    model_fe(e);
    old_fc = mframe;
    @(posedge clk); #1;
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total += 3;
      if (commit !== 1'b1) begin bad++; $display("FAIL cen_commit_hold got=%b exp=1", commit); end
      if (sprite_x !== 12'(old_x)) begin bad++; $display("FAIL cen_x_hold got=%0d exp=%0d", sprite_x, old_x); end
      if (frame_cnt !== 16'(old_fc)) begin bad++; $display("FAIL cen_fc_hold got=%0d exp=%0d", frame_cnt, old_fc); end
    end
    cen = 1'b1;
    @(posedge clk); #1;
    total += 2;
    if (commit !== 1'b0) begin bad++; $display("FAIL cen_commit_end got=%b exp=0", commit); end
    if (sprite_x !== 12'(e.x)) begin bad++; $display("FAIL cen_x_new got=%0d exp=%0d", sprite_x, e.x); end
    vh = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_pending();
    cfg_write(0, 100);
    cfg_write(3, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    run_frame();
    cfg_write(3, 0);
    run_frame();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_frames();
    test_write_commit();
    test_bounce();
    test_back_to_back();
    test_blink();
    test_cen_freeze();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
